write_operation_ctrl: RTL and testbench

Write-domain control for the dual-clock FIFO. It is the upstream counterpart of the read-side pointer/empty logic. It maintains the binary and Gray write pointers and generates the memory write address and enable. It derives full, almost-full, fill level and a sticky overflow flag by comparing against the read Gray pointer after that pointer has been synchronized into the write domain. Its registered Gray pointer wptr is what gets synchronized into the read domain.

---
 rtl/write_operation_ctrl.sv | 85 ++++++++
 tb/tb_write_operation_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/write_operation_ctrl.sv
// Write-domain pointer and status control for a dual-clock FIFO.
// Keeps the binary/Gray write pointers, drives the memory write port and
// derives full, almost-full, fill level and a sticky overflow flag from the
// read Gray pointer already synchronized into the write clock domain.
module write_operation_ctrl #(
  parameter int SIZE         = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            winc,
  input  logic [SIZE:0]   wq2_rptr,
  input  logic            overflow_clr,
  output logic            wen,
  output logic [SIZE-1:0] waddr,
  output logic [SIZE:0]   wptr,
  output logic            wfull,
  output logic            walmost_full,
  output logic [SIZE:0]   wlevel,
  output logic            woverflow
);

  localparam logic [SIZE:0] ThreshW = (SIZE+1)'(AFULL_THRESH);

  logic [SIZE:0] wbin_q, wbin_d;
  logic [SIZE:0] wptr_q, wptr_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic [SIZE:0] wlevel_q, wlevel_d;
  logic          wovf_q, wovf_d;
  logic [SIZE:0] rbin_sync;
  logic [SIZE:0] full_cmp;

  // Writes are only accepted while the registered full flag is low.
  assign wen   = winc & ~wfull_q;
  assign waddr = wbin_q[SIZE-1:0];

  // Convert the synchronized read Gray pointer back to binary: each binary
  // bit is the XOR of all Gray bits from the MSB down to that position.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= SIZE; i++) begin
      rbin_sync[i] = ^(wq2_rptr >> i);
    end
  end

  // Next pointer values and the status flags they imply.  The level is
  // measured against a stale read pointer, so it can only overstate fill.
  always_comb begin
    wbin_d   = wbin_q + {{SIZE{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    full_cmp = {~wq2_rptr[SIZE:SIZE-1], wq2_rptr[SIZE-2:0]};
    wfull_d  = (wptr_d == full_cmp);
    wlevel_d = wbin_d - rbin_sync;
    wafull_d = (wlevel_d >= ThreshW);
    wovf_d   = (wovf_q & ~overflow_clr) | (winc & wfull_q);
  end

  // State registers; an asserted reset discards everything, including any
  // write being requested at that moment.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_write_operation_ctrl.sv
// Self-checking bench for write_operation_ctrl (SIZE=4, AFULL_THRESH=12).
module tb_write_operation_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       overflow_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int nTests = 0;
  int nFail  = 0;

  write_operation_ctrl #(.SIZE(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .overflow_clr(overflow_clr), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
    .woverflow(woverflow)
  );

  // Free-running write clock, 10 time units per period.
  always #5 wclk = ~wclk;

  function automatic int gray(int n);
    return (n ^ (n >> 1)) & 31;
  endfunction

  // Gray decode by search: the count whose Gray code matches.
  function automatic int ungray(logic [4:0] g);
    for (int n = 0; n < 32; n++) begin
      if (gray(n) == int'(g)) return n;
    end
    return 0;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    nTests++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: count of accepted words, fill level as plain
  // subtraction, full means exactly 16 words outstanding.
  int mW, mLevel;
  bit mFull, mAfull, mOvf;

  // Model update on each write-clock edge, reset asynchronously like the DUT.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mW = 0; mLevel = 0; mFull = 0; mAfull = 0; mOvf = 0;
    end else begin
      bit acc, nOvf;
      acc    = winc && !mFull;
      nOvf   = (mOvf && !overflow_clr) || (winc && mFull);
      mW     = (mW + int'(acc)) % 32;
      mLevel = (mW - ungray(wq2_rptr) + 32) % 32;
      mFull  = (mLevel == 16);
      mAfull = (mLevel >= 12);
      mOvf   = nOvf;
    end
  end

  // Compare all outputs against the model on the falling edge.
  always @(negedge wclk) begin
    if (wrst_n) begin
      checkOutput("cyc.wen",    int'(wen),          int'(winc && !mFull));
      checkOutput("cyc.waddr",  int'(waddr),        mW % 16);
      checkOutput("cyc.wptr",   int'(wptr),         gray(mW));
      checkOutput("cyc.wfull",  int'(wfull),        int'(mFull));
      checkOutput("cyc.afull",  int'(walmost_full), int'(mAfull));
      checkOutput("cyc.wlevel", int'(wlevel),       mLevel);
      checkOutput("cyc.ovf",    int'(woverflow),    int'(mOvf));
    end
  end

  // Set inputs, let one edge consume them, return shortly after that edge.
  task automatic applyStimulus(logic inc, logic [4:0] rptr, logic clr);
    winc = inc; wq2_rptr = rptr; overflow_clr = clr;
    @(posedge wclk);
    #2;
  endtask

  int  w;
  bit  sawAddrWrap, sawPtrWrap;
  logic [3:0] prevAddr;
  logic [4:0] prevPtr;

  initial begin
    wrst_n = 1'b0; winc = 1'b1; wq2_rptr = '0; overflow_clr = 1'b0;
    repeat (2) @(posedge wclk);
    #2;
    checkOutput("rst.wptr",   int'(wptr),      0);
    checkOutput("rst.waddr",  int'(waddr),     0);
    checkOutput("rst.wfull",  int'(wfull),     0);
    checkOutput("rst.wlevel", int'(wlevel),    0);
    checkOutput("rst.ovf",    int'(woverflow), 0);
    checkOutput("rst.wen",    int'(wen),       1);
    winc = 1'b0;
    wrst_n = 1'b1;
    @(posedge wclk); #2;

    // Fill sixteen words with the reader parked at zero.
    for (int i = 0; i < 16; i++) begin
      checkOutput("fill.waddr", int'(waddr), i);
      applyStimulus(1'b1, 5'b00000, 1'b0);
      if (i == 10) checkOutput("fill.afull11", int'(walmost_full), 0);
      if (i == 11) checkOutput("fill.afull12", int'(walmost_full), 1);
      if (i == 0)  checkOutput("fill.wptr1",   int'(wptr), 5'b00001);
      if (i == 1)  checkOutput("fill.wptr2",   int'(wptr), 5'b00011);
      if (i == 2)  checkOutput("fill.wptr3",   int'(wptr), 5'b00010);
    end
    checkOutput("fill.wptr16",   int'(wptr),   5'b11000);
    checkOutput("fill.wlevel16", int'(wlevel), 16);
    checkOutput("fill.wfull",    int'(wfull),  1);

    // Overflow while full, then clear, then set and clear together.
    winc = 1'b1; #1;
    checkOutput("ovf.wen", int'(wen), 0);
    applyStimulus(1'b1, 5'b00000, 1'b0);
    checkOutput("ovf.wptr", int'(wptr),      5'b11000);
    checkOutput("ovf.set",  int'(woverflow), 1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("ovf.clr",  int'(woverflow), 0);
    applyStimulus(1'b1, 5'b00000, 1'b1);
    checkOutput("ovf.setwins", int'(woverflow), 1);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    checkOutput("ovf.clr2", int'(woverflow), 0);

    // Reader advances by one word, then one more write refills.
    applyStimulus(1'b0, 5'b00001, 1'b0);
    checkOutput("drain.wfull",  int'(wfull),  0);
    checkOutput("drain.wlevel", int'(wlevel), 15);
    applyStimulus(1'b1, 5'b00001, 1'b0);
    checkOutput("drain.refull", int'(wfull), 1);
    checkOutput("drain.wptr",   int'(wptr),  5'b11001);

    // Full write coinciding with a read advance: dropped, full clears.
    applyStimulus(1'b1, 5'b00011, 1'b0);
    checkOutput("simul.wptr",   int'(wptr),   5'b11001);
    checkOutput("simul.wfull",  int'(wfull),  0);
    checkOutput("simul.wlevel", int'(wlevel), 15);

    // Bring the reader to two behind, then stream 40 words across the wrap.
    w = 17;
    applyStimulus(1'b0, 5'(gray(w - 2)), 1'b0);
    checkOutput("wrap.start", int'(wlevel), 2);
    sawAddrWrap = 0; sawPtrWrap = 0;
    for (int i = 0; i < 40; i++) begin
      prevAddr = waddr; prevPtr = wptr;
      applyStimulus(1'b1, 5'(gray((w + 30) % 32)), 1'b0);
      w = (w + 1) % 32;
      if (prevAddr == 4'd15 && waddr == 4'd0) sawAddrWrap = 1;
      if (prevPtr == 5'b10000 && wptr == 5'b00000) sawPtrWrap = 1;
      checkOutput("wrap.nofull", int'(wfull), 0);
      checkOutput("wrap.levelInRange", int'(wlevel >= 2 && wlevel <= 4), 1);
    end
    checkOutput("wrap.addrWrap", int'(sawAddrWrap), 1);
    checkOutput("wrap.ptrWrap",  int'(sawPtrWrap),  1);
    checkOutput("wrap.waddr",    int'(waddr),       w % 16);

    // Asynchronous reset between edges while writes are flowing.
    winc = 1'b1;
    @(posedge wclk); #3;
    wrst_n = 1'b0;
    #1;
    checkOutput("arst.wptr",   int'(wptr),         0);
    checkOutput("arst.waddr",  int'(waddr),        0);
    checkOutput("arst.wfull",  int'(wfull),        0);
    checkOutput("arst.afull",  int'(walmost_full), 0);
    checkOutput("arst.wlevel", int'(wlevel),       0);
    checkOutput("arst.ovf",    int'(woverflow),    0);
    checkOutput("arst.wen",    int'(wen),          1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
